// File: rtl/intcode_io_bank_if.sv
// CPU-side bus of the Intcode I/O bank: word address, write/read strobes,
// write data in, and the read data plus its bus-drive enable.
interface intcode_io_bank_if #(
  parameter int WIDTH = 32
);
  logic [31:0]      address_bus;
  logic             ram_write;
  logic             bus_read;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             data_oe;

  modport master (
    output address_bus, ram_write, bus_read, data_in,
    input  data_out, data_oe
  );

  modport slave (
    input  address_bus, ram_write, bus_read, data_in,
    output data_out, data_oe
  );
endinterface

// File: rtl/intcode_io_bank.sv
// FIFO-buffered Intcode I/O bank: CHANNELS input/output FIFO pairs mapped
// at BASE_ADDR, four words per channel (input data, output data, status,
// control), with a level interrupt on non-empty input FIFOs.
module intcode_io_bank #(
  parameter int          WIDTH     = 32,
  parameter int          DEPTH     = 8,
  parameter int          CHANNELS  = 2,
  parameter logic [31:0] BASE_ADDR = 32'hFFFF0000
) (
  input  logic                      clock,
  input  logic                      reset,
  intcode_io_bank_if.slave          bus,
  input  logic [CHANNELS*WIDTH-1:0] host_in_data,
  input  logic [CHANNELS-1:0]       host_in_valid,
  output logic [CHANNELS-1:0]       host_in_ready,
  output logic [CHANNELS*WIDTH-1:0] host_out_data,
  output logic [CHANNELS-1:0]       host_out_valid,
  input  logic [CHANNELS-1:0]       host_out_ready,
  output logic                      irq
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [31:0]               offset;
  logic                      mapped;
  logic [1:0]                reg_sel;
  logic [3:0]                chan_sel;
  logic                      data_oe;
  logic [WIDTH-1:0]          rd_data;
  logic [CHANNELS*WIDTH-1:0] rd_flat;
  logic [CHANNELS-1:0]       irq_src;

  // Subtracting the base makes addresses below it wrap to huge offsets,
  // so one unsigned compare covers both ends of the window.
  assign offset   = bus.address_bus - BASE_ADDR;
  assign mapped   = offset < 32'(4 * CHANNELS);
  assign reg_sel  = offset[1:0];
  assign chan_sel = offset[5:2];
  assign data_oe  = mapped && (reg_sel != 2'd1) && !bus.ram_write;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    logic [WIDTH-1:0] in_mem  [DEPTH];
    logic [WIDTH-1:0] out_mem [DEPTH];
    logic [PTR_W-1:0] in_rd, in_wr, out_rd, out_wr;
    logic [CNT_W-1:0] in_cnt, out_cnt;
    logic             in_uf, out_of, irq_en;
    logic             sel, ctrl_wr, flush_in, flush_out, clr_err;
    logic             in_empty, in_full, out_empty, out_full;
    logic             rd_req, wr_req, in_push, in_pop, out_push, out_pop;
    logic [23:0]      status;
    logic [WIDTH-1:0] in_head, word;

    assign sel       = mapped && (chan_sel == 4'(c));
    assign ctrl_wr   = sel && (reg_sel == 2'd3) && bus.ram_write;
    assign flush_in  = ctrl_wr && bus.data_in[0];
    assign flush_out = ctrl_wr && bus.data_in[1];
    assign clr_err   = ctrl_wr && bus.data_in[2];

    assign in_empty  = (in_cnt == '0);
    assign in_full   = (in_cnt == CNT_W'(DEPTH));
    assign out_empty = (out_cnt == '0);
    assign out_full  = (out_cnt == CNT_W'(DEPTH));

    // Push/pop qualifiers look only at registered counts: a full FIFO
    // never accepts a push and an empty one never pops, even if the
    // opposite operation happens in the same cycle.
    assign rd_req   = sel && (reg_sel == 2'd0) && bus.bus_read && !bus.ram_write;
    assign wr_req   = sel && (reg_sel == 2'd1) && bus.ram_write;
    assign in_push  = host_in_valid[c] && !in_full;
    assign in_pop   = rd_req && !in_empty;
    assign out_push = wr_req && !out_full;
    assign out_pop  = host_out_ready[c] && !out_empty;

    // Storage needs no reset; empty FIFOs never expose it.
    always_ff @(posedge clock) begin
      if (in_push)  in_mem[in_wr]   <= host_in_data[c*WIDTH +: WIDTH];
      if (out_push) out_mem[out_wr] <= bus.data_in;
    end

    // Pointers, counts, sticky errors and irq enable; flush beats any
    // same-cycle push or pop, a new error beats a same-cycle clear.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        in_rd   <= '0;
        in_wr   <= '0;
        in_cnt  <= '0;
        out_rd  <= '0;
        out_wr  <= '0;
        out_cnt <= '0;
        in_uf   <= 1'b0;
        out_of  <= 1'b0;
        irq_en  <= 1'b0;
      end else begin
        if (flush_in) begin
          in_rd  <= '0;
          in_wr  <= '0;
          in_cnt <= '0;
        end else begin
          if (in_push) in_wr <= in_wr + PTR_W'(1);
          if (in_pop)  in_rd <= in_rd + PTR_W'(1);
          in_cnt <= in_cnt + CNT_W'(in_push) - CNT_W'(in_pop);
        end
        if (flush_out) begin
          out_rd  <= '0;
          out_wr  <= '0;
          out_cnt <= '0;
        end else begin
          if (out_push) out_wr <= out_wr + PTR_W'(1);
          if (out_pop)  out_rd <= out_rd + PTR_W'(1);
          out_cnt <= out_cnt + CNT_W'(out_push) - CNT_W'(out_pop);
        end
        if (rd_req && in_empty)     in_uf <= 1'b1;
        else if (clr_err)           in_uf <= 1'b0;
        if (wr_req && out_full)     out_of <= 1'b1;
        else if (clr_err)           out_of <= 1'b0;
        if (ctrl_wr)                irq_en <= bus.data_in[3];
      end
    end

    assign status = {8'(out_cnt), 8'(in_cnt), 2'b00, out_of, in_uf,
                     out_full, out_empty, in_full, in_empty};
    assign in_head = in_empty ? '0 : in_mem[in_rd];

    // Per-channel read word, zero unless this channel is addressed.
    always_comb begin
      word = '0;
      if (sel) begin
        case (reg_sel)
          2'd0:    word = in_head;
          2'd2:    word = WIDTH'(status);
          2'd3:    word = WIDTH'({irq_en, 3'b000});
          default: word = '0;
        endcase
      end
    end

    assign rd_flat[c*WIDTH +: WIDTH]       = word;
    assign host_in_ready[c]                = !in_full;
    assign host_out_valid[c]               = !out_empty;
    assign host_out_data[c*WIDTH +: WIDTH] = out_empty ? '0 : out_mem[out_rd];
    assign irq_src[c]                      = irq_en && !in_empty;
  end

  // Only the addressed channel contributes a non-zero word, so OR-merge.
  always_comb begin
    rd_data = '0;
    for (int c = 0; c < CHANNELS; c++) rd_data = rd_data | rd_flat[c*WIDTH +: WIDTH];
  end

  assign bus.data_out = data_oe ? rd_data : '0;
  assign bus.data_oe  = data_oe;

  // Interrupt is a registered view of the enabled non-empty inputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) irq <= 1'b0;
    else        irq <= |irq_src;
  end

endmodule
